cp0_reg: RTL and testbench
==========================

CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 we_i  in  1  write strobe from decoded MTC0 (cp0_write).
REQ-004 waddr_i  in  5  CP0 register number for write (rd field).
REQ-005 raddr_i  in  5  CP0 register number for read (MFC0 rd field).
REQ-006 data_i  in  32  write data (rt value).
REQ-007 int_i  in  6  hardware interrupt lines, level.
REQ-008 excepttype_i  in  32  exception code this cycle; 0 = none.
REQ-009 current_inst_addr_i  in  32  PC of excepting instruction.
REQ-010 is_in_delayslot_i  in  1  excepting instruction is in a delay slot.
REQ-011 bad_addr_i  in  32  faulting address for AdEL/AdES.
REQ-012 data_o  out  32  read data for raddr_i, combinational from current register state, no write bypass.
REQ-013 status_o, cause_o, epc_o  out  32 each  live copies of Status, Cause, EPC.
REQ-014 timer_int_o  out  1  timer interrupt pending.

Function
REQ-015 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15) = 0x0000_4220 constant, Config(16) = 0x0000_8000 constant; other addresses read 0, writes ignored.
REQ-016 Count: internal tick bit toggles every cycle; Count += 1 (mod 2^32, wraps 0xFFFF_FFFF -> 0) on cycles where tick = 1, i.e. half clock rate.
REQ-017 Write to Count: Count <= data_i, tick <= 0; write beats the increment in the same cycle.
REQ-018 Timer: timer_int_o set to 1 when Compare != 0 and Count == Compare (registered values); stays set until a write to Compare.
REQ-019 Write to Compare: Compare <= data_i, timer_int_o <= 0; the clear beats a same-cycle set.
REQ-020 Status write mask: only bits 15:8 (IM), 1 (EXL), 0 (IE) writable; all other bits keep their value.
REQ-021 Cause write mask: only bits 9:8 (IP1:0, software interrupts) writable.
REQ-022 Cause[15:10] <= int_i every cycle, with Cause[15] <= int_i[5] | timer_int_o.
REQ-023 EPC and BadVAddr: fully writable via we_i.
REQ-024 Exception codes: 0x1 Int -> ExcCode 0x00; 0x4 AdEL -> 0x04; 0x5 AdES -> 0x05; 0x8 Sys -> 0x08; 0x9 Bp -> 0x09; 0xa RI -> 0x0a; 0xc Ov -> 0x0c; 0xe ERET.
REQ-025 Exception taken (code in REQ-024 other than 0xe), Status.EXL = 0: EPC <= current_inst_addr_i - 4 and Cause.BD (bit 31) <= 1 if is_in_delayslot_i, else EPC <= current_inst_addr_i and BD <= 0.
REQ-026 Exception taken, Status.EXL = 1: EPC and BD unchanged.
REQ-027 Any taken exception: Status.EXL <= 1; Cause[6:2] <= ExcCode.
REQ-028 AdEL/AdES additionally: BadVAddr <= bad_addr_i.
REQ-029 ERET (0xe): Status.EXL <= 0; no other field changes.
REQ-030 Unlisted nonzero excepttype_i: no state change.
REQ-031 Exception or ERET in the same cycle as we_i: the exception/ERET update applies and the MTC0 write is dropped entirely; Count/timer/int_i sampling continue normally.

Reset
REQ-032 rst = 1 at a clock edge: Count = 0, tick = 0, Compare = 0, Status = 0x1040_0000, Cause = 0, EPC = 0, BadVAddr = 0, timer_int_o = 0.
REQ-033 Reset overrides all writes, exceptions and counting in that cycle; reset mid-count restarts Count from 0.

Verification
REQ-034 After reset, read 12/13/15 -> 0x1040_0000 / 0x0 / 0x0000_4220; Count reaches 5 after 10 cycles.
REQ-035 Write Compare = 3, Count = 0 -> timer_int_o rises when Count == 3, Cause[15] = 1 next cycle; write Compare = 0x10 -> timer_int_o = 0 next cycle.
REQ-036 Write Status = 0xFFFF_FFFF -> reads 0x1040_FF03; write Cause = 0xFFFF_FFFF with int_i = 0 -> reads 0x0000_0300.
REQ-037 excepttype_i = 0x4, PC = 0xBFC0_0100, delayslot = 1, bad_addr_i = 0x1234_5671 -> EPC = 0xBFC0_00FC, BD = 1, ExcCode = 4, BadVAddr = 0x1234_5671, EXL = 1; a second exception 0xc -> EPC unchanged, ExcCode = 0x0c; then 0xe -> EXL = 0.
REQ-038 we_i to EPC with data 0xDEAD_BEEF coincident with excepttype_i = 0x8, PC = 0x8000_0000 -> EPC = 0x8000_0000, write dropped.
REQ-039 Count = 0xFFFF_FFFF -> wraps to 0 on the next tick; rst asserted mid-run -> all registers at REQ-032 values next cycle.

Source files
------------

// File: rtl/cp0_reg.sv
// -----------------------------------------------------------------------------
// cp0_reg -- MIPS32-style coprocessor 0 register file.
//
// Holds the CP0 registers used by the pipeline for exceptions and the timer:
// BadVAddr, Count, Compare, Status, Cause and EPC, plus the constant PRId and
// Config. The registers are written by MTC0, read by MFC0, and updated by the
// exception/ERET logic. Count advances at half the clock rate. A timer
// interrupt is raised when Count matches a nonzero Compare.
//
// Ports
//   clk                  clock; all state changes on the rising edge
//   rst                  synchronous, active-high reset
//   we_i                 MTC0 write strobe
//   waddr_i   [4:0]      register number for the MTC0 write
//   raddr_i   [4:0]      register number for the MFC0 read
//   data_i    [31:0]     MTC0 write data
//   int_i     [5:0]      hardware interrupt lines (level)
//   excepttype_i [31:0]  exception code this cycle (0 = none, 0xe = ERET)
//   current_inst_addr_i  PC of the excepting instruction
//   is_in_delayslot_i    excepting instruction sits in a branch delay slot
//   bad_addr_i [31:0]    faulting address for AdEL/AdES
//   data_o    [31:0]     MFC0 read data (current state, no write bypass)
//   status_o/cause_o/epc_o  live copies of Status, Cause and EPC
//   timer_int_o          timer interrupt pending
// -----------------------------------------------------------------------------
module cp0_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  // CP0 register numbers.
  typedef enum logic [4:0] {
    REG_BADVADDR = 5'd8,
    REG_COUNT    = 5'd9,
    REG_COMPARE  = 5'd11,
    REG_STATUS   = 5'd12,
    REG_CAUSE    = 5'd13,
    REG_EPC      = 5'd14,
    REG_PRID     = 5'd15,
    REG_CONFIG   = 5'd16
  } cp0_addr_e;

  localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
  localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;
  localparam logic [31:0] STATUS_RESET = 32'h1040_0000;
  // Software-writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8].
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Bit positions used by the exception logic.
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  // Values presented on excepttype_i by the exception unit.
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [31:0] count_q;
  logic        tick_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        timer_q;

  // ---------------------------------------------------------------------------
  // Exception decode
  // ---------------------------------------------------------------------------
  logic       exc_taken;
  logic       exc_addr_err;
  logic       eret;
  logic [4:0] exc_code;

  // NOTE: every signal driven here gets a default first, so that no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    exc_taken    = 1'b0;
    exc_addr_err = 1'b0;
    eret         = 1'b0;
    exc_code     = 5'h00;
    case (excepttype_i)
      EXC_INT:  begin exc_taken = 1'b1; exc_code = 5'h00; end
      EXC_ADEL: begin exc_taken = 1'b1; exc_code = 5'h04; exc_addr_err = 1'b1; end
      EXC_ADES: begin exc_taken = 1'b1; exc_code = 5'h05; exc_addr_err = 1'b1; end
      EXC_SYS:  begin exc_taken = 1'b1; exc_code = 5'h08; end
      EXC_BP:   begin exc_taken = 1'b1; exc_code = 5'h09; end
      EXC_RI:   begin exc_taken = 1'b1; exc_code = 5'h0A; end
      EXC_OV:   begin exc_taken = 1'b1; exc_code = 5'h0C; end
      EXC_ERET: eret = 1'b1;
      default:  ; // zero or unrecognised code: no exception activity
    endcase
  end

  // An exception or ERET in the same cycle squashes the MTC0 completely.
  logic mtc0_en;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_badvaddr;

  assign mtc0_en     = we_i & ~exc_taken & ~eret;
  assign wr_count    = mtc0_en & (waddr_i == REG_COUNT);
  assign wr_compare  = mtc0_en & (waddr_i == REG_COMPARE);
  assign wr_status   = mtc0_en & (waddr_i == REG_STATUS);
  assign wr_cause    = mtc0_en & (waddr_i == REG_CAUSE);
  assign wr_epc      = mtc0_en & (waddr_i == REG_EPC);
  assign wr_badvaddr = mtc0_en & (waddr_i == REG_BADVADDR);

  // EXL is sampled from the registered Status: a nested exception (EXL already
  // set) must not overwrite EPC/BD of the outer one.
  logic        exl;
  logic [31:0] exc_epc;

  assign exl     = status_q[STATUS_EXL];
  assign exc_epc = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                     : current_inst_addr_i;

  // ---------------------------------------------------------------------------
  // Count: increments on every other cycle. A write restarts the half-rate
  // phase so the written value is held for two cycles.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (wr_count) begin
      count_q <= data_i;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (tick_q) count_q <= count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare and timer interrupt. The interrupt is sticky until software
  // rewrites Compare; that write wins over a match in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else if (wr_compare) begin
      compare_q <= data_i;
      timer_q   <= 1'b0;
    end else if ((compare_q != '0) && (count_q == compare_q)) begin
      timer_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status: exceptions set EXL, ERET clears it, MTC0 touches IM/EXL/IE only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
    end else if (exc_taken) begin
      status_q[STATUS_EXL] <= 1'b1;
    end else if (eret) begin
      status_q[STATUS_EXL] <= 1'b0;
    end else if (wr_status) begin
      status_q <= (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    end
  end

  // ---------------------------------------------------------------------------
  // Cause: IP[7:2] track the interrupt lines every cycle (IP7 also carries the
  // timer), ExcCode/BD are loaded on exceptions, IP[1:0] are software-set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else begin
      cause_q[15:10] <= {int_i[5] | timer_q, int_i[4:0]};
      if (exc_taken) begin
        cause_q[6:2] <= exc_code;
        if (!exl) cause_q[CAUSE_BD] <= is_in_delayslot_i;
      end else if (wr_cause) begin
        cause_q[9:8] <= data_i[9:8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // EPC and BadVAddr
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= '0;
    end else if (exc_taken && !exl) begin
      epc_q <= exc_epc;
    end else if (wr_epc) begin
      epc_q <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
    end else if (exc_taken && exc_addr_err) begin
      badvaddr_q <= bad_addr_i;
    end else if (wr_badvaddr) begin
      badvaddr_q <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // MFC0 read port: current register contents, no forwarding of this cycle's
  // write.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_o = '0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_q;
      REG_COUNT:    data_o = count_q;
      REG_COMPARE:  data_o = compare_q;
      REG_STATUS:   data_o = status_q;
      REG_CAUSE:    data_o = cause_q;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID_VALUE;
      REG_CONFIG:   data_o = CONFIG_VALUE;
      default:      data_o = '0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// -----------------------------------------------------------------------------
// tb_cp0_reg -- self-checking bench for cp0_reg.
//
// A behavioural model of the CP0 registers is stepped once per clock from the
// same inputs as the DUT. Every cycle the live outputs and the MFC0 read port
// are compared against it. Directed scenarios cover reset, timer, write masks,
// exceptions, MTC0/exception collision, Count wrap and mid-run reset, followed
// by a randomized phase.
// -----------------------------------------------------------------------------
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] data_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .raddr_i             (raddr_i),
    .data_i              (data_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .bad_addr_i          (bad_addr_i),
    .data_o              (data_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_badv;
  bit          m_tick, m_timer;

  int exc_list [7] = '{1, 4, 5, 8, 9, 10, 12};

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h0000_8000;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_badv;
    bit          n_tick, n_timer, exc, eret, mtc0;
    logic [4:0]  code;
    if (rst) begin
      m_count = 0; m_tick = 0; m_compare = 0; m_status = 32'h1040_0000;
      m_cause = 0; m_epc = 0; m_badv = 0; m_timer = 0;
      return;
    end
    exc  = 0;
    code = 0;
    foreach (exc_list[i])
      if (excepttype_i == 32'(exc_list[i])) begin
        exc  = 1;
        code = (exc_list[i] == 1) ? 5'd0 : 5'(exc_list[i]);
      end
    eret = (excepttype_i == 32'hE);
    mtc0 = we_i && !exc && !eret;

    if (mtc0 && waddr_i == 5'd9) begin
      n_count = data_i; n_tick = 0;
    end else begin
      n_count = m_count + (m_tick ? 32'd1 : 32'd0);
      n_tick  = !m_tick;
    end

    n_compare = m_compare;
    n_timer   = m_timer || (m_compare != 0 && m_count == m_compare);
    if (mtc0 && waddr_i == 5'd11) begin
      n_compare = data_i; n_timer = 0;
    end

    n_status = m_status;
    if (exc)       n_status[1] = 1'b1;
    else if (eret) n_status[1] = 1'b0;
    else if (mtc0 && waddr_i == 5'd12)
      n_status = (m_status & ~32'h0000_FF03) | (data_i & 32'h0000_FF03);

    n_cause        = m_cause;
    n_cause[15:10] = {int_i[5] | m_timer, int_i[4:0]};
    n_epc          = m_epc;
    n_badv         = m_badv;
    if (exc) begin
      n_cause[6:2] = code;
      if (!m_status[1]) begin
        n_epc       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        n_cause[31] = is_in_delayslot_i;
      end
      if (code == 5'd4 || code == 5'd5) n_badv = bad_addr_i;
    end else if (mtc0) begin
      case (waddr_i)
        5'd13:   n_cause[9:8] = data_i[9:8];
        5'd14:   n_epc = data_i;
        5'd8:    n_badv = data_i;
        default: ;
      endcase
    end

    m_count = n_count; m_tick = n_tick; m_compare = n_compare; m_timer = n_timer;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: model and DUT see the same inputs, outputs compared 1 ns later.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("status_o", status_o, m_status);
    check("cause_o", cause_o, m_cause);
    check("epc_o", epc_o, m_epc);
    check("timer_int_o", {31'b0, timer_int_o}, {31'b0, m_timer});
    check("data_o", data_o, m_read(raddr_i));
  endtask

  // Read a register through the MFC0 port and compare with a fixed value.
  task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
    raddr_i = a;
    #1;
    check(tag, data_o, exp);
  endtask

  task automatic idle();
    rst = 0; we_i = 0; waddr_i = 0; data_i = 0;
    excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    we_i = 1; waddr_i = a; data_i = d;
    step();
    idle();
  endtask

  task automatic raise(input logic [31:0] code, input logic [31:0] pc, input bit ds,
                       input logic [31:0] badaddr);
    idle();
    excepttype_i = code; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = badaddr;
    step();
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [4:0] addr_pool [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
  logic [31:0] code_pool [12] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE,
                                  32'h2, 32'h3, 32'h20, 32'hD};

  initial begin
    idle();
    int_i   = 0;
    raddr_i = 5'd12;
    rst     = 1;
    step();
    step();
    rst = 0;

    // Reset values through the read port, then Count at half rate.
    peek(5'd12, "reset_status", 32'h1040_0000);
    peek(5'd13, "reset_cause", 32'h0);
    peek(5'd15, "prid", 32'h0000_4220);
    raddr_i = 5'd9;
    for (int i = 0; i < 10; i++) step();
    peek(5'd9, "count_after_10", 32'd5);
    peek(5'd16, "config", 32'h0000_8000);

    // Timer: Compare = 3, Count = 0, wait for the interrupt.
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    begin
      int n = 0;
      while (!timer_int_o && n < 20) begin step(); n++; end
      check("timer_rise", {31'b0, timer_int_o}, 32'd1);
      peek(5'd9, "count_at_timer", 32'd3);
    end
    step();
    check("cause_ip7_timer", {31'b0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'h10);
    check("timer_clear", {31'b0, timer_int_o}, 32'd0);

    // Write masks.
    mtc0(5'd12, 32'hFFFF_FFFF);
    peek(5'd12, "status_mask", 32'h1040_FF03);
    step(); // Cause[15] catches up with the cleared timer
    mtc0(5'd13, 32'hFFFF_FFFF);
    peek(5'd13, "cause_mask", 32'h0000_0300);
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'h0);

    // AdEL in a delay slot, then a nested Ov, then ERET.
    raise(32'h4, 32'hBFC0_0100, 1'b1, 32'h1234_5671);
    check("adel_epc", epc_o, 32'hBFC0_00FC);
    check("adel_bd", {31'b0, cause_o[31]}, 32'd1);
    check("adel_exccode", {27'b0, cause_o[6:2]}, 32'h4);
    check("adel_exl", {31'b0, status_o[1]}, 32'd1);
    peek(5'd8, "adel_badvaddr", 32'h1234_5671);
    raise(32'hC, 32'h8000_1000, 1'b0, 32'h0);
    check("nested_epc", epc_o, 32'hBFC0_00FC);
    check("nested_exccode", {27'b0, cause_o[6:2]}, 32'hC);
    raise(32'hE, 32'h0, 1'b0, 32'h0);
    check("eret_exl", {31'b0, status_o[1]}, 32'd0);

    // MTC0 to EPC colliding with a syscall: the write is dropped.
    idle();
    we_i = 1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h8000_0000;
    step();
    idle();
    check("collide_epc", epc_o, 32'h8000_0000);
    raise(32'hE, 32'h0, 1'b0, 32'h0);

    // Count wrap: written value held for two cycles, then 0.
    mtc0(5'd9, 32'hFFFF_FFFF);
    raddr_i = 5'd9;
    step();
    peek(5'd9, "count_hold", 32'hFFFF_FFFF);
    step();
    peek(5'd9, "count_wrap", 32'h0);

    // Mid-run reset with dirty state.
    mtc0(5'd14, 32'h1111_2222);
    mtc0(5'd11, 32'h55);
    int_i = 6'h3F;
    step();
    rst = 1;
    step();
    rst = 0;
    int_i = 0;
    check("rst_status", status_o, 32'h1040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    peek(5'd9, "rst_count", 32'h0);
    peek(5'd11, "rst_compare", 32'h0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst     = ($urandom_range(0, 199) == 0);
      int_i   = 6'($urandom);
      raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addr_pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 2) == 0) begin
        we_i    = 1;
        waddr_i = ($urandom_range(0, 4) == 0) ? 5'($urandom) : addr_pool[$urandom_range(0, 8)];
        data_i  = $urandom;
        if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
          data_i = m_count + 32'($urandom_range(0, 6));
        if (waddr_i == 5'd9 && $urandom_range(0, 3) == 0)
          data_i = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 4) < 2) begin
        excepttype_i        = ($urandom_range(0, 11) == 0) ? $urandom : code_pool[$urandom_range(0, 11)];
        current_inst_addr_i = $urandom;
        is_in_delayslot_i   = 1'($urandom);
        bad_addr_i          = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
